// File: rtl/alu_seq_if.sv
// Bus between the control sequencer and the registered ALU: instruction
// issue handshake, operand inputs, result write port and flag outputs.
interface alu_seq_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [15:0]      instruction;
  logic [WIDTH-1:0] rddata;
  logic [WIDTH-1:0] rsdata;
  logic             skip_clr;
  logic [WIDTH-1:0] aluout;
  logic             wen;
  logic             done;
  logic             busy;
  logic             carry;
  logic             skip;

  // Sequencer side: issues instructions, consumes results and flags
  modport master (
    output start, instruction, rddata, rsdata, skip_clr,
    input  aluout, wen, done, busy, carry, skip
  );

  // ALU side
  modport slave (
    input  start, instruction, rddata, rsdata, skip_clr,
    output aluout, wen, done, busy, carry, skip
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ARM-class ALU with internal CARRY/SKIP flags, single-cycle
// arithmetic/logic ops and a WIDTH-cycle shift-add multiply, all behind a
// start/busy/done handshake. Operands are latched when start is accepted.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2} state_t;

  state_t state_reg, state_next;

  logic               arm_reg, cw_reg, c_reg, carry_reg, skip_reg;
  logic [3:0]         cond_reg;
  logic [WIDTH-1:0]   result_reg, mcand_reg, mplier_reg;
  logic [2*WIDTH-1:0] product_reg, addend, product_next;
  logic [CNT_W-1:0]   count_reg;

  // Decode of the instruction presented with start
  logic       in_arm, in_cin, accept, start_mul, unused_bits;
  logic [2:0] in_op;
  logic [WIDTH:0] single;

  assign in_arm      = (bus.instruction[15:14] == 2'b11);
  assign in_op       = bus.instruction[6:4];
  assign accept      = (state_reg == IDLE) && bus.start;
  assign start_mul   = in_arm && (in_op == 3'b100);
  assign unused_bits = ^bus.instruction[3:0];

  // Carry-in selection, using the carry flag as it stands at accept time
  always_comb begin
    in_cin = 1'b0;
    case (bus.instruction[13:12])
      2'b00: in_cin = 1'b0;
      2'b01: in_cin = 1'b1;
      2'b10: in_cin = carry_reg;
      2'b11: in_cin = bus.rsdata[WIDTH-1];
      default: in_cin = 1'b0;
    endcase
  end

  // Single-cycle result {c, r}, computed from the live operands at accept
  always_comb begin
    single = '0;
    case (in_op)
      3'b000: single = {1'b0, bus.rddata} + {1'b0, bus.rsdata} + {{WIDTH{1'b0}}, in_cin};
      3'b001: single = {1'b0, bus.rddata} + {1'b0, ~bus.rsdata} + {{WIDTH{1'b0}}, in_cin};
      3'b010: single = {1'b0, bus.rsdata} + {{WIDTH{1'b0}}, in_cin};
      3'b011: single = {bus.rsdata[0], in_cin, bus.rsdata[WIDTH-1:1]};
      3'b101: single = {1'b0, bus.rddata & bus.rsdata};
      3'b110: single = {1'b0, bus.rddata | bus.rsdata};
      3'b111: single = {1'b0, bus.rddata ^ bus.rsdata};
      default: single = '0;
    endcase
  end

  // One shift-add step: add the multiplicand shifted by the current bit index
  assign addend       = mplier_reg[count_reg] ? ({{WIDTH{1'b0}}, mcand_reg} << count_reg) : '0;
  assign product_next = product_reg + addend;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.start) state_next = start_mul ? MUL : EXEC;
      EXEC: state_next = IDLE;
      MUL:  if (count_reg == LAST) state_next = EXEC;
      default: state_next = IDLE;
    endcase
  end

  // Operand latching, single-cycle result capture and multiply iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_reg     <= 1'b0;
      cw_reg      <= 1'b0;
      cond_reg    <= '0;
      c_reg       <= 1'b0;
      result_reg  <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      product_reg <= '0;
      count_reg   <= '0;
    end else if (accept) begin
      arm_reg     <= in_arm;
      cw_reg      <= bus.instruction[7];
      cond_reg    <= bus.instruction[11:8];
      mcand_reg   <= bus.rddata;
      mplier_reg  <= bus.rsdata;
      product_reg <= '0;
      count_reg   <= '0;
      if (!start_mul) begin
        result_reg <= single[WIDTH-1:0];
        c_reg      <= single[WIDTH];
      end
    end else if (state_reg == MUL) begin
      product_reg <= product_next;
      count_reg   <= count_reg + CNT_W'(1);
      if (count_reg == LAST) begin
        result_reg <= product_next[WIDTH-1:0];
        c_reg      <= |product_next[2*WIDTH-1:WIDTH];
      end
    end
  end

  // Condition evaluated on the completed result and the post-update carry
  logic carry_new, cond_hit;
  assign carry_new = cw_reg ? c_reg : carry_reg;

  always_comb begin
    cond_hit = 1'b0;
    if (!cond_reg[3]) begin
      case (cond_reg[2:0])
        3'b000: cond_hit = 1'b0;
        3'b001: cond_hit = 1'b1;
        3'b010: cond_hit = carry_new;
        3'b011: cond_hit = !carry_new;
        3'b100: cond_hit = (result_reg == '0);
        3'b101: cond_hit = (result_reg != '0);
        3'b110: cond_hit = result_reg[WIDTH-1];
        3'b111: cond_hit = !result_reg[WIDTH-1];
        default: cond_hit = 1'b0;
      endcase
    end
  end

  // Flag registers: a completing ARM instruction beats a concurrent skip_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_reg <= 1'b0;
      skip_reg  <= 1'b0;
    end else if ((state_reg == EXEC) && arm_reg) begin
      if (cw_reg) carry_reg <= c_reg;
      skip_reg <= cond_hit;
    end else if (bus.skip_clr) begin
      skip_reg <= 1'b0;
    end
  end

  assign bus.aluout = result_reg;
  assign bus.done   = (state_reg == EXEC);
  assign bus.wen    = (state_reg == EXEC) && arm_reg;
  assign bus.busy   = (state_reg != IDLE);
  assign bus.carry  = carry_reg;
  assign bus.skip   = skip_reg;
endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq: a 16-bit instance checked against an
// arithmetic reference model, plus a small 8-bit instance.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(16)) bus16 ();
  alu_seq_if #(.WIDTH(8))  bus8 ();

  alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int   vectors = 0;
  int   miscompares = 0;
  logic m_carry = 1'b0;
  logic m_skip  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_eval(input int w, input logic [3:0] cc,
                                     input longint unsigned r, input logic c);
    logic msb;
    msb = ((r >> (w - 1)) & 1) != 0;
    if (cc[3]) return 1'b0;
    case (cc[2:0])
      3'd0: return 1'b0;
      3'd1: return 1'b1;
      3'd2: return c;
      3'd3: return !c;
      3'd4: return r == 0;
      3'd5: return r != 0;
      3'd6: return msb;
      default: return !msb;
    endcase
  endfunction

  // Instruction semantics expressed as plain integer arithmetic
  function automatic void model(input int w, input logic [15:0] instr,
                                input longint unsigned rd, input longint unsigned rs,
                                input logic cur_carry,
                                output logic arm, output longint unsigned r, output logic c);
    longint unsigned mask, s, cin;
    mask = (64'd1 << w) - 1;
    arm  = (instr[15:14] == 2'b11);
    case (instr[13:12])
      2'd0: cin = 0;
      2'd1: cin = 1;
      2'd2: cin = cur_carry;
      default: cin = (rs >> (w - 1)) & 1;
    endcase
    s = 0;
    c = 1'b0;
    case (instr[6:4])
      3'd0: s = rd + rs + cin;
      3'd1: s = rd + ((~rs) & mask) + cin;
      3'd2: s = rs + cin;
      3'd3: s = ((rs & 1) << w) | (cin << (w - 1)) | (rs >> 1);
      3'd4: begin
        s = rd * rs;
        c = (s >> w) != 0;
        s = s & mask;
      end
      3'd5: s = rd & rs;
      3'd6: s = rd | rs;
      default: s = rd ^ rs;
    endcase
    r = s & mask;
    if (instr[6:4] != 3'd4) c = ((s >> w) & 1) != 0;
  endfunction

  // Issue one instruction to the 16-bit ALU and check its completion
  task automatic run16(input logic [15:0] instr, input logic [15:0] rd,
                       input logic [15:0] rs, input logic clr, input logic inject);
    logic arm, c, newc, exp_skip;
    longint unsigned r;
    int exp_lat, lat;
    model(16, instr, rd, rs, m_carry, arm, r, c);
    exp_lat  = (arm && instr[6:4] == 3'b100) ? 17 : 1;
    newc     = (arm && instr[7]) ? c : m_carry;
    exp_skip = arm ? cond_eval(16, instr[11:8], r, newc) : (clr ? 1'b0 : m_skip);

    @(negedge clk);
    bus16.start = 1'b1;
    bus16.instruction = instr;
    bus16.rddata = rd;
    bus16.rsdata = rs;
    bus16.skip_clr = clr;
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
    bus16.instruction = 16'($urandom);
    bus16.rddata = 16'($urandom);
    bus16.rsdata = 16'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!bus16.done) begin
        bus16.start = inject && (lat == 3);
        if (bus16.start) bus16.instruction = 16'hC000;
      end
    end while (!bus16.done && lat < 40);
    bus16.start = 1'b0;
    check("latency", lat, exp_lat);
    check("wen", {31'd0, bus16.wen}, {31'd0, arm});
    check("busy_at_done", {31'd0, bus16.busy}, 32'd1);
    if (arm) check("aluout", {16'd0, bus16.aluout}, r[31:0]);
    @(posedge clk);
    #1;
    bus16.skip_clr = 1'b0;
    check("carry", {31'd0, bus16.carry}, {31'd0, newc});
    check("skip", {31'd0, bus16.skip}, {31'd0, exp_skip});
    check("busy_after", {31'd0, bus16.busy}, 32'd0);
    m_carry = newc;
    m_skip  = exp_skip;
    $display("instr=%h rd=%h rs=%h clr=%0d -> aluout=%h carry=%0d skip=%0d lat=%0d",
             instr, rd, rs, clr, bus16.aluout, bus16.carry, bus16.skip, lat);
  endtask

  initial begin
    logic [15:0] instr;
    int hits, lat;
    rst_n = 1'b0;
    bus16.start = 1'b0; bus16.instruction = '0; bus16.rddata = '0; bus16.rsdata = '0; bus16.skip_clr = 1'b0;
    bus8.start  = 1'b0; bus8.instruction  = '0; bus8.rddata  = '0; bus8.rsdata  = '0; bus8.skip_clr  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, bus16.busy}, 32'd0);
    check("rst_done", {31'd0, bus16.done}, 32'd0);
    check("rst_wen", {31'd0, bus16.wen}, 32'd0);
    check("rst_aluout", {16'd0, bus16.aluout}, 32'd0);
    check("rst_carry", {31'd0, bus16.carry}, 32'd0);
    check("rst_skip", {31'd0, bus16.skip}, 32'd0);
    rst_n = 1'b1;

    // Directed cases
    run16(16'hC480, 16'hFFFF, 16'h0001, 1'b0, 1'b0);   // add wraps to 0, carry=1, skip=1
    run16(16'hF2B0, 16'h0000, 16'h8003, 1'b0, 1'b0);   // XSR -> 0xC001, carry=1
    @(negedge clk); bus16.skip_clr = 1'b1;
    @(negedge clk); bus16.skip_clr = 1'b0;
    check("skip_clr", {31'd0, bus16.skip}, 32'd0);
    m_skip = 1'b0;
    run16(16'hC0C0, 16'h0123, 16'h0100, 1'b0, 1'b1);   // MUL with ignored mid-run start
    run16(16'h4012, 16'h1234, 16'h5678, 1'b0, 1'b0);   // non-ARM
    run16(16'hC480, 16'hFFFF, 16'h0001, 1'b0, 1'b0);   // set carry and skip before abort

    // Reset in the middle of a multiply
    @(negedge clk);
    bus16.start = 1'b1; bus16.instruction = 16'hC0C0; bus16.rddata = 16'h00FF; bus16.rsdata = 16'h00FF;
    @(negedge clk);
    bus16.start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, bus16.busy}, 32'd0);
    check("abort_carry", {31'd0, bus16.carry}, 32'd0);
    check("abort_skip", {31'd0, bus16.skip}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    repeat (24) begin
      @(negedge clk);
      if (bus16.done || bus16.wen) hits++;
    end
    check("abort_no_done", hits, 0);
    m_carry = 1'b0;
    m_skip  = 1'b0;
    $display("reset mid-MUL: busy=%0d carry=%0d skip=%0d", bus16.busy, bus16.carry, bus16.skip);

    // Randomized instruction stream
    for (int i = 0; i < 150; i++) begin
      instr = 16'($urandom);
      if ($urandom_range(3) != 0) instr[15:14] = 2'b11;
      run16(instr, 16'($urandom), 16'($urandom), ($urandom_range(3) == 0),
            (instr[6:4] == 3'b100) && $urandom_range(1) == 1);
    end

    // 8-bit build: subtract with borrow, then a multiply
    @(negedge clk);
    bus8.start = 1'b1; bus8.instruction = 16'hD690; bus8.rddata = 8'h05; bus8.rsdata = 8'h07;
    @(posedge clk); #1; bus8.start = 1'b0;
    @(negedge clk);
    check("w8_done", {31'd0, bus8.done}, 32'd1);
    check("w8_wen", {31'd0, bus8.wen}, 32'd1);
    check("w8_aluout", {24'd0, bus8.aluout}, 32'h0000_00FE);
    @(posedge clk); #1;
    check("w8_carry", {31'd0, bus8.carry}, 32'd0);
    check("w8_skip", {31'd0, bus8.skip}, 32'd1);
    $display("w8 sub: aluout=%h carry=%0d skip=%0d", bus8.aluout, bus8.carry, bus8.skip);
    @(negedge clk);
    bus8.start = 1'b1; bus8.instruction = 16'hC0C0; bus8.rddata = 8'h12; bus8.rsdata = 8'h34;
    @(posedge clk); #1; bus8.start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus8.done && lat < 30);
    check("w8_mul_lat", lat, 9);
    check("w8_mul_aluout", {24'd0, bus8.aluout}, 32'h0000_00A8);
    @(posedge clk); #1;
    check("w8_mul_carry", {31'd0, bus8.carry}, 32'd1);
    $display("w8 mul: aluout=%h carry=%0d lat=%0d", bus8.aluout, bus8.carry, lat);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
